// File: rtl/ser_frame_pkg.sv
// Shared constants and state encoding for the serial framer and its companion receiver.
// Frame on the wire: start bit 0, 4-bit length MSB first, then payload LSB first.
package ser_frame_pkg;

    localparam int unsigned LEN_W      = 4;
    localparam int unsigned MAX_BITS   = (1 << LEN_W) - 1;
    localparam int unsigned IDX_W      = $clog2(LEN_W);
    localparam logic        IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StLen,
        StData
    } state_e;

endpackage

// File: rtl/ser_frame_transmitter_if.sv
// Handshake and serial-line bundle between a frame requester and the framer.
interface ser_frame_transmitter_if;
    import ser_frame_pkg::*;

    logic                clkEn;
    logic                start;
    logic [LEN_W-1:0]    len;
    logic [MAX_BITS-1:0] data;
    logic                serOut;
    logic                busy;
    logic                done;
    logic [LEN_W-1:0]    count_out;

    modport master (
        output clkEn, start, len, data,
        input  serOut, busy, done, count_out
    );

    modport slave (
        input  clkEn, start, len, data,
        output serOut, busy, done, count_out
    );

endinterface

// File: rtl/ser_frame_shift.sv
// Loadable right-shift register holding the payload; bit 0 is always the next bit to send.
module ser_frame_shift
    import ser_frame_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                shift_i,
    input  logic [MAX_BITS-1:0] data_i,
    output logic                lsb_o
);

    logic [MAX_BITS-1:0] shreg_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= data_i;
        end else if (shift_i) begin
            shreg_q <= {1'b0, shreg_q[MAX_BITS-1:1]};
        end
    end

    assign lsb_o = shreg_q[0];

endmodule

// File: rtl/ser_frame_transmitter.sv
// Parallel-to-serial framer: start bit, length field, payload, all advanced by clkEn.
// Every output is a flop; serout_q is loaded with the bit for the period that begins.
module ser_frame_transmitter
    import ser_frame_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    ser_frame_transmitter_if.slave  bus
);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count_q;
    logic             serout_q;
    logic             busy_q;
    logic             done_q;

    logic             load;
    logic             shift_en;
    logic             lsb;

    assign load = (state_q == StIdle) && bus.start;

    // Shift as each payload bit is copied into serout_q so lsb already holds the next one.
    always_comb begin
        shift_en = 1'b0;
        if (bus.clkEn) begin
            if (state_q == StLen && idx_q == '0 && len_q != '0) begin
                shift_en = 1'b1;
            end
            if (state_q == StData && count_q != LEN_W'(1)) begin
                shift_en = 1'b1;
            end
        end
    end

    ser_frame_shift u_shift (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .shift_i (shift_en),
        .data_i  (bus.data),
        .lsb_o   (lsb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            len_q    <= '0;
            count_q  <= '0;
            serout_q <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        len_q    <= bus.len;
                        count_q  <= bus.len;
                        serout_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= StStart;
                    end
                end
                StStart: begin
                    if (bus.clkEn) begin
                        idx_q    <= IDX_W'(LEN_W - 1);
                        serout_q <= len_q[LEN_W-1];
                        state_q  <= StLen;
                    end
                end
                StLen: begin
                    if (bus.clkEn) begin
                        if (idx_q != '0) begin
                            idx_q    <= idx_q - IDX_W'(1);
                            serout_q <= len_q[idx_q - IDX_W'(1)];
                        end else if (len_q != '0) begin
                            serout_q <= lsb;
                            state_q  <= StData;
                        end else begin
                            serout_q <= IDLE_LEVEL;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= StIdle;
                        end
                    end
                end
                StData: begin
                    if (bus.clkEn) begin
                        count_q <= count_q - LEN_W'(1);
                        if (count_q == LEN_W'(1)) begin
                            serout_q <= IDLE_LEVEL;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= StIdle;
                        end else begin
                            serout_q <= lsb;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.serOut    = serout_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.count_out = count_q;

endmodule
